// File: rtl/song_reader.sv
// song_reader
//   Walks one 32-entry song held in the 128x12 song ROM, one note at a time.
//   Each {note, duration} word goes to the note player. Duration is counted
//   down in beats. The block pauses while play is low. A song ends after
//   index 31 has played, or when an entry with duration 0 is read.
//   The ROM word is {note, duration}, and its read data arrives one clock
//   after the address is presented.
//
// Ports
//   clk         : system clock
//   reset_n     : asynchronous, active-low reset
//   play        : level; 1 = run/resume, 0 = pause (or release after done)
//   song        : song select, sampled only while idle
//   beat        : 1-clk pulse per beat
//   rom_dout    : ROM read data {note, duration}
//   rom_addr    : registered ROM address {song, index}
//   note        : current note (0 = rest)
//   duration    : duration of the current note, in beats
//   new_note    : 1-clk pulse when note/duration update
//   note_active : high while playing and not paused
//   song_done   : 1-clk pulse on reaching the end of the song
module song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    beat,
  input  logic [NOTE_W+DUR_W-1:0] rom_dout,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    new_note,
  output logic                    note_active,
  output logic                    song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [SONG_W-1:0]         song_q, song_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic [DUR_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [SONG_W+IDX_W-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]         note_q, note_d;
  logic [DUR_W-1:0]          duration_q, duration_d;
  logic                      new_note_q, new_note_d;
  logic                      song_done_q, song_done_d;

  logic [NOTE_W-1:0]         rom_note;
  logic [DUR_W-1:0]          rom_dur;
  logic [IDX_W-1:0]          index_next;

  assign rom_note   = rom_dout[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur    = rom_dout[DUR_W-1:0];
  assign index_next = index_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    index_d     = index_q;
    beat_cnt_d  = beat_cnt_q;
    rom_addr_d  = rom_addr_q;
    note_d      = note_q;
    duration_d  = duration_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play) begin
          song_d     = song;
          index_d    = '0;
          rom_addr_d = {song, {IDX_W{1'b0}}};
          state_d    = S_FETCH;
        end
      end
      // The ROM registers rom_addr on this edge.
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // A duration of 0 marks the end of the song. It is not a note.
        if (rom_dur == '0) begin
          note_d      = '0;
          song_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          note_d     = rom_note;
          duration_d = rom_dur;
          beat_cnt_d = rom_dur;
          new_note_d = 1'b1;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        // While paused (play=0) beats are dropped and everything is held.
        if (play && beat) begin
          if (beat_cnt_q == DUR_W'(1)) begin
            // Index 31 ends the song. The address is not advanced into
            // the next song's entries.
            if (index_q == '1) begin
              song_done_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              index_d    = index_next;
              rom_addr_d = {song_q, index_next};
              state_d    = S_FETCH;
            end
          end else begin
            beat_cnt_d = beat_cnt_q - DUR_W'(1);
          end
        end
      end
      S_DONE: begin
        // Wait for play to be released so the song never auto-repeats.
        if (!play) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      song_q      <= '0;
      index_q     <= '0;
      beat_cnt_q  <= '0;
      rom_addr_q  <= '0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      index_q     <= index_d;
      beat_cnt_q  <= beat_cnt_d;
      rom_addr_q  <= rom_addr_d;
      note_q      <= note_d;
      duration_q  <= duration_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign note        = note_q;
  assign duration    = duration_q;
  assign new_note    = new_note_q;
  assign song_done   = song_done_q;
  assign note_active = (state_q == S_PLAY) && play;

endmodule
